// File: rtl/pn_job_arbiter.sv
// pn_job_arbiter: round-robin arbiter sharing one PN evaluator among NREQ token streams.
// Optional watchdog on the result wait is enabled by defining PNARB_WATCHDOG_EN.
module pn_job_arbiter #(
    parameter int NREQ    = 2,
    parameter int MAX_TOK = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NREQ-1:0]                        req,
    output logic [NREQ-1:0]                        gnt,
    input  logic [NREQ-1:0]                        tok_valid,
    input  logic [NREQ-1:0]                        tok_last,
    input  logic [2*NREQ-1:0]                      tok_mode,
    input  logic [NREQ-1:0]                        tok_operator,
    input  logic [3*NREQ-1:0]                      tok_in,
    output logic                                   pn_in_valid,
    output logic [1:0]                             pn_mode,
    output logic                                   pn_operator,
    output logic [2:0]                             pn_in,
    input  logic                                   pn_out_valid,
    input  logic signed [31:0]                     pn_out,
    output logic                                   rsp_valid,
    output logic [(NREQ>1?$clog2(NREQ):1)-1:0]     rsp_id,
    output logic signed [31:0]                     rsp_data,
    output logic                                   rsp_last,
    output logic                                   rsp_err
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT, DRAIN, GAP} state_t;

    state_t             state, state_nx;
    logic [IDW-1:0]     ptr, id, win;
    logic               found;
    logic [3:0]         cnt;
    logic               err, gap, bv, to_p, wd_hit;
    logic signed [31:0] rbuf;
    logic               tv, tl;

    assign tv = tok_valid[id];
    assign tl = tok_last[id];

`ifdef PNARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;

    assign wd_hit = (state == WAIT) && !pn_out_valid && (wd == WDW'(TIMEOUT - 1));

    // Watchdog: held at zero until the job enters WAIT, then counts silent cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd <= '0;
        else if (state != WAIT)
            wd <= '0;
        else if (!pn_out_valid)
            wd <= wd + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign wd_hit = 1'b0;
`endif

    // Round-robin search starting at ptr; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic for the job sequence.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? ARB : IDLE;
            ARB:     state_nx = found ? LOAD : IDLE;
            LOAD:    state_nx = (tv && tl) ? WAIT : LOAD;
            WAIT:    state_nx = pn_out_valid ? DRAIN : (wd_hit ? GAP : WAIT);
            DRAIN:   state_nx = pn_out_valid ? DRAIN : GAP;
            GAP:     state_nx = gap ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    // Grant, token forwarding and result buffering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= '0;
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            gap         <= 1'b0;
            bv          <= 1'b0;
            to_p        <= 1'b0;
            rbuf        <= '0;
            pn_in_valid <= 1'b0;
            pn_mode     <= '0;
            pn_operator <= 1'b0;
            pn_in       <= '0;
        end else begin
            pn_in_valid <= 1'b0;
            to_p        <= wd_hit;
            gap         <= (state == GAP) && !gap;
            case (state)
                ARB: begin
                    cnt <= '0;
                    err <= 1'b0;
                    if (found) begin
                        gnt <= NREQ'(1) << win;
                        id  <= win;
                        ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    end
                end
                LOAD: begin
                    if (tv) begin
                        if (cnt < 4'(MAX_TOK)) begin
                            pn_in_valid <= 1'b1;
                            pn_operator <= tok_operator[id];
                            pn_in       <= tok_in[int'(id)*3 +: 3];
                            cnt         <= cnt + 1'b1;
                            if (cnt == '0)
                                pn_mode <= tok_mode[int'(id)*2 +: 2];
                        end else begin
                            err <= 1'b1;
                        end
                        if (tl)
                            gnt <= '0;
                    end
                end
                WAIT: begin
                    bv   <= pn_out_valid;
                    rbuf <= pn_out_valid ? pn_out : '0;
                end
                DRAIN: begin
                    bv   <= pn_out_valid;
                    rbuf <= pn_out_valid ? pn_out : '0;
                end
                GAP: begin
                    bv <= 1'b0;
                    if (gap)
                        err <= 1'b0;
                end
                default: bv <= 1'b0;
            endcase
        end
    end

    // A buffered result is the last one when the PN burst has just ended.
    assign rsp_valid = bv | to_p;
    assign rsp_data  = bv ? rbuf : '0;
    assign rsp_id    = rsp_valid ? id : '0;
    assign rsp_last  = to_p | (bv & ~pn_out_valid);
    assign rsp_err   = to_p | (bv & ~pn_out_valid & err);

endmodule

// File: tb/tb_pn_job_arbiter.sv
// tb_pn_job_arbiter: directed bench for pn_job_arbiter with a PN stub driven from tasks.
// Watchdog scenario runs when PNARB_WATCHDOG_EN is defined, otherwise the indefinite-wait case.
module tb_pn_job_arbiter;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req = '0, gnt;
    logic [1:0]         tok_valid = '0, tok_last = '0, tok_operator = '0;
    logic [3:0]         tok_mode = '0;
    logic [5:0]         tok_in = '0;
    logic               pn_in_valid, pn_operator;
    logic [1:0]         pn_mode;
    logic [2:0]         pn_in;
    logic               pn_out_valid = 1'b0;
    logic signed [31:0] pn_out = '0, rsp_data;
    logic               rsp_valid, rsp_id, rsp_last, rsp_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pv_cnt  = 0;
    logic [34:0] rq[$];

    pn_job_arbiter #(.NREQ(2), .MAX_TOK(12), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .tok_valid(tok_valid), .tok_last(tok_last), .tok_mode(tok_mode),
        .tok_operator(tok_operator), .tok_in(tok_in),
        .pn_in_valid(pn_in_valid), .pn_mode(pn_mode), .pn_operator(pn_operator), .pn_in(pn_in),
        .pn_out_valid(pn_out_valid), .pn_out(pn_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Monitor: count forwarded tokens and record every response, sampled mid-cycle.
    always @(negedge clk) begin
        if (pn_in_valid) pv_cnt++;
        if (rsp_valid) rq.push_back({rsp_err, rsp_last, rsp_id, rsp_data});
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [1:0] m, input logic op, input logic [2:0] v,
                        input logic last);
        tok_valid = '0;
        tok_last  = '0;
        tok_valid[r] = 1'b1;
        tok_last[r]  = last;
        tok_operator[r] = op;
        tok_mode[2*r +: 2] = m;
        tok_in[3*r +: 3]   = v;
        tick();
        tok_valid = '0;
        tok_last  = '0;
    endtask

    task automatic grant(input int r, output int waited);
        req[r] = 1'b1;
        waited = 0;
        while (!gnt[r] && waited < 20) begin
            tick();
            waited++;
        end
        req[r] = 1'b0;
    endtask

    task automatic pn_emit(input int v);
        pn_out_valid = 1'b1;
        pn_out = v;
        tick();
    endtask

    task automatic pn_end();
        pn_out_valid = 1'b0;
        pn_out = '0;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tok_valid = '0;
        tok_last = '0;
        pn_out_valid = 1'b0;
        pn_out = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_tests++;
        if ({gnt, pn_in_valid, pn_mode, pn_operator, pn_in, rsp_valid, rsp_id, rsp_data, rsp_last, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b piv=%b mode=%0d rv=%b data=%0d", gnt, pn_in_valid, pn_mode, rsp_valid, rsp_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int w;
        rq.delete();
        pv_cnt = 0;
        grant(0, w);
        n_tests++;
        if (w != 2 || gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b after %0d cycles, want 01 after 2", gnt, w);
        end
        send(0, 2'd3, 1'b0, 3'd2, 1'b0);
        n_tests++;
        if ({pn_in_valid, pn_mode, pn_operator, pn_in} !== {1'b1, 2'd3, 1'b0, 3'd2}) begin
            n_fail++;
            $display("FAIL single_tok1: got %b want %b", {pn_in_valid, pn_mode, pn_operator, pn_in}, {1'b1, 2'd3, 1'b0, 3'd2});
        end
        send(0, 2'd0, 1'b0, 3'd3, 1'b0);
        n_tests++;
        if ({pn_in_valid, pn_mode, pn_operator, pn_in} !== {1'b1, 2'd3, 1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL single_tok2_mode_held: got %b want %b", {pn_in_valid, pn_mode, pn_operator, pn_in}, {1'b1, 2'd3, 1'b0, 3'd3});
        end
        send(0, 2'd0, 1'b1, 3'd0, 1'b1);
        n_tests++;
        if ({gnt, pn_in_valid, pn_mode, pn_operator, pn_in} !== {2'b00, 1'b1, 2'd3, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL single_last_tok: got %b want %b", {gnt, pn_in_valid, pn_mode, pn_operator, pn_in}, {2'b00, 1'b1, 2'd3, 1'b1, 3'd0});
        end
        tick();
        pn_emit(5);
        pn_end();
        n_tests++;
        if (rq.size() != 1 || rq[0] !== {1'b0, 1'b1, 1'b0, 32'sd5} || pv_cnt != 3) begin
            n_fail++;
            $display("FAIL single_rsp: got n=%0d rsp=%h tokens=%0d want n=1 rsp=%h tokens=3", rq.size(), rq[0], pv_cnt, {1'b0, 1'b1, 1'b0, 32'sd5});
        end
    endtask

    task automatic test_multi();
        int w;
        rq.delete();
        pv_cnt = 0;
        grant(1, w);
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL multi_grant: got %b want 10", gnt);
        end
        send(1, 2'd0, 1'b1, 3'd0, 1'b0);
        send(1, 2'd0, 1'b0, 3'd4, 1'b0);
        send(1, 2'd0, 1'b0, 3'd1, 1'b0);
        send(1, 2'd0, 1'b1, 3'd2, 1'b0);
        send(1, 2'd0, 1'b0, 3'd2, 1'b0);
        send(1, 2'd0, 1'b0, 3'd3, 1'b1);
        n_tests++;
        if (pn_mode !== 2'd0 || pn_in !== 3'd3) begin
            n_fail++;
            $display("FAIL multi_fwd: got mode=%0d in=%0d want mode=0 in=3", pn_mode, pn_in);
        end
        tick();
        pn_emit(6);
        pn_emit(5);
        pn_end();
        n_tests++;
        if (rq.size() != 2 || rq[0] !== {1'b0, 1'b0, 1'b1, 32'sd6} || rq[1] !== {1'b0, 1'b1, 1'b1, 32'sd5} || pv_cnt != 6) begin
            n_fail++;
            $display("FAIL multi_rsp: got n=%0d r0=%h r1=%h tokens=%0d want n=2 r0=%h r1=%h tokens=6",
                     rq.size(), rq[0], rq[1], pv_cnt, {1'b0, 1'b0, 1'b1, 32'sd6}, {1'b0, 1'b1, 1'b1, 32'sd5});
        end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        req = 2'b11;
        grant(0, w);
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_first: got %b want 01", gnt);
        end
        send(0, 2'd0, 1'b0, 3'd1, 1'b1);
        tick();
        pn_emit(1);
        pn_end();
        grant(1, w);
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL rr_second: got %b want 10", gnt);
        end
        send(1, 2'd0, 1'b0, 3'd2, 1'b1);
        tick();
        pn_emit(2);
        pn_end();
        req = 2'b11;
        grant(0, w);
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_wrap: got %b want 01", gnt);
        end
        req = '0;
        send(0, 2'd0, 1'b0, 3'd1, 1'b1);
        tick();
        pn_emit(1);
        pn_end();
    endtask

    task automatic test_overlength();
        int w;
        rq.delete();
        grant(0, w);
        pv_cnt = 0;
        for (int i = 0; i < 13; i++)
            send(0, 2'd1, 1'b0, 3'(i % 8), i == 12);
        tick();
        n_tests++;
        if (pv_cnt != 12 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL overlength_fwd: got tokens=%0d gnt=%b want 12 00", pv_cnt, gnt);
        end
        pn_emit(7);
        pn_end();
        n_tests++;
        if (rq.size() != 1 || rq[0] !== {1'b1, 1'b1, 1'b0, 32'sd7}) begin
            n_fail++;
            $display("FAIL overlength_err: got n=%0d rsp=%h want n=1 rsp=%h", rq.size(), rq[0], {1'b1, 1'b1, 1'b0, 32'sd7});
        end
    endtask

`ifdef PNARB_WATCHDOG_EN
    task automatic test_watchdog();
        int w;
        int n;
        rq.delete();
        grant(0, w);
        send(0, 2'd0, 1'b0, 3'd1, 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != 64 || {rsp_err, rsp_last, rsp_data} !== {1'b1, 1'b1, 32'sd0}) begin
            n_fail++;
            $display("FAIL watchdog_rsp: got after %0d cycles err=%b last=%b data=%0d want 64 1 1 0", n, rsp_err, rsp_last, rsp_data);
        end
        tick();
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL watchdog_single: got rsp_valid=%b want 0", rsp_valid);
        end
        grant(1, w);
        n_tests++;
        if (gnt !== 2'b10 || w > 5) begin
            n_fail++;
            $display("FAIL watchdog_next: got gnt=%b after %0d want 10 within 5", gnt, w);
        end
        send(1, 2'd0, 1'b0, 3'd1, 1'b1);
        tick();
        pn_emit(1);
        pn_end();
    endtask
`else
    task automatic test_watchdog();
        int w;
        rq.delete();
        grant(0, w);
        send(0, 2'd0, 1'b0, 3'd1, 1'b1);
        repeat (100) tick();
        n_tests++;
        if (rq.size() != 0) begin
            n_fail++;
            $display("FAIL wait_forever: got %0d rsp want 0", rq.size());
        end
        pn_emit(9);
        pn_end();
        n_tests++;
        if (rq.size() != 1 || rq[0] !== {1'b0, 1'b1, 1'b0, 32'sd9}) begin
            n_fail++;
            $display("FAIL wait_late_rsp: got n=%0d rsp=%h want n=1 rsp=%h", rq.size(), rq[0], {1'b0, 1'b1, 1'b0, 32'sd9});
        end
    endtask
`endif

    task automatic test_reset_mid();
        int w;
        rq.delete();
        grant(0, w);
        send(0, 2'd2, 1'b0, 3'd4, 1'b0);
        send(0, 2'd2, 1'b0, 3'd5, 1'b0);
        n_tests++;
        if ({gnt, pn_in_valid} !== {2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_pre: got gnt=%b piv=%b want 01 1", gnt, pn_in_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt, pn_in_valid, rsp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_async: got gnt=%b piv=%b rv=%b want 00 0 0", gnt, pn_in_valid, rsp_valid);
        end
        #2;
        rst_n = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (rq.size() != 0 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_norsp: got n=%0d gnt=%b want 0 00", rq.size(), gnt);
        end
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_round_robin();
        test_overlength();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
